dac_sample_streamer: RTL and testbench

- Back-end stage of the plb_dac peripheral: takes 10-bit samples from the PLB user-logic registers over a valid/ready handshake and buffers them in a small FIFO.
- Generates the DAC data clock (S_DCLKIO) with a programmable divider and presents one sample per DAC clock on S_Data.
- Sequences the power-down, wake and run states and drives the DAC static mode pins.

---
 rtl/dac_sample_streamer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dac_sample_streamer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_streamer.sv
// ---------------------------------------------------------------------------
// dac_sample_streamer
//
// Back-end stage of the plb_dac peripheral. Samples arrive from the register
// bank over a valid/ready handshake and are buffered in a small FIFO. The
// block generates the DAC data clock (S_DCLKIO) with a programmable divider.
// It presents one sample per DAC clock on S_Data and sequences the DAC
// through power-down (IDLE), wake-up (WAKE), streaming (RUN) and an orderly
// stop (STOP).
//
// Ports
//   Bus2IP_Clk     system clock
//   Bus2IP_Resetn  asynchronous active-low reset
//   s_data/s_valid/s_ready  sample input handshake (push on s_valid&&s_ready)
//   cfg_enable     run request
//   cfg_clk_div    DCLKIO half-period minus one, in system cycles
//   cfg_format     0 = offset binary, 1 = two's complement
//   underrun_clr   single-cycle pulse clearing the sticky underrun flag
//   fifo_level     current FIFO occupancy
//   underrun       sticky: the FIFO was empty at a sample slot
//   running        high while in RUN
//   S_Data         DAC data, bit 0 is the MSB
//   S_DCLKIO       DAC data clock (DAC latches on its rising edge)
//   S_PWRDN        DAC power-down, active high
//   S_Format       registered copy of cfg_format
//   S_PinMD/S_ClkMD static DAC mode pins (1 / 0)
// ---------------------------------------------------------------------------
module dac_sample_streamer #(
    parameter int C_DATA_WIDTH  = 10,
    parameter int C_FIFO_DEPTH  = 16,
    parameter int C_DIV_WIDTH   = 16,
    parameter int C_WAKE_CYCLES = 64
) (
    input  logic                             Bus2IP_Clk,
    input  logic                             Bus2IP_Resetn,
    input  logic [C_DATA_WIDTH-1:0]          s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             cfg_enable,
    input  logic [C_DIV_WIDTH-1:0]           cfg_clk_div,
    input  logic                             cfg_format,
    input  logic                             underrun_clr,
    output logic [$clog2(C_FIFO_DEPTH):0]    fifo_level,
    output logic                             underrun,
    output logic                             running,
    output logic [0:C_DATA_WIDTH-1]          S_Data,
    output logic                             S_DCLKIO,
    output logic                             S_PWRDN,
    output logic                             S_Format,
    output logic                             S_PinMD,
    output logic                             S_ClkMD
);

    localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAKE_W = $clog2(C_WAKE_CYCLES + 1);

    localparam logic [WAKE_W-1:0]       WAKE_LAST = WAKE_W'(C_WAKE_CYCLES - 1);
    localparam logic [LVL_W-1:0]        LVL_FULL  = LVL_W'(C_FIFO_DEPTH);
    // Offset-binary midscale: only the MSB set.
    localparam logic [C_DATA_WIDTH-1:0] MID_OB    = {1'b1, {(C_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAKE,
        ST_RUN,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [WAKE_W-1:0]         wake_cnt_q, wake_cnt_d;
    logic [C_DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
    logic [C_DIV_WIDTH-1:0]    div_q, div_d;        // latched cfg_clk_div
    logic                      dclk_q, dclk_d;
    logic [C_DATA_WIDTH-1:0]   data_q, data_d;
    logic                      pwrdn_q, pwrdn_d;
    logic                      format_q;
    logic                      underrun_q, underrun_d;
    logic                      ready_q, ready_d;
    logic                      running_q, running_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;

    logic [C_DATA_WIDTH-1:0]   mem [C_FIFO_DEPTH];

    logic                      push;
    logic                      pop;
    logic                      urun_set;
    logic                      div_tc;
    logic                      stopping;
    logic [C_DATA_WIDTH-1:0]   midscale;

    assign midscale = cfg_format ? '0 : MID_OB;
    assign push     = s_valid && ready_q;
    assign div_tc   = (div_cnt_q == div_q);

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        dclk_d     = dclk_q;
        data_d     = data_q;
        pwrdn_d    = pwrdn_q;
        pop        = 1'b0;
        urun_set   = 1'b0;
        stopping   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pwrdn_d    = 1'b1;
                dclk_d     = 1'b0;
                data_d     = midscale;
                div_cnt_d  = '0;
                wake_cnt_d = '0;
                if (cfg_enable) begin
                    state_d = ST_WAKE;
                    pwrdn_d = 1'b0;
                end
            end

            ST_WAKE: begin
                pwrdn_d = 1'b0;
                dclk_d  = 1'b0;
                data_d  = midscale;
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                    pwrdn_d = 1'b1;
                end else if (wake_cnt_q == WAKE_LAST) begin
                    // First rising DCLKIO lands exactly C_WAKE_CYCLES after
                    // PWRDN was released, with midscale already on the bus.
                    state_d   = ST_RUN;
                    dclk_d    = 1'b1;
                    div_cnt_d = '0;
                    div_d     = cfg_clk_div;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end

            ST_RUN, ST_STOP: begin
                if (div_tc) begin
                    div_cnt_d = '0;
                    dclk_d    = !dclk_q;
                end else begin
                    div_cnt_d = div_cnt_q + C_DIV_WIDTH'(1);
                end

                // A RUN cycle that sees cfg_enable low already behaves as
                // STOP, so a disable during a high phase ends on this very
                // period's falling edge.
                stopping = (state_q == ST_STOP) || !cfg_enable;

                if (stopping) begin
                    if (div_tc && dclk_q) begin
                        // Falling edge that ends the period: power down
                        // without consuming a sample, FIFO left intact.
                        state_d = ST_IDLE;
                        pwrdn_d = 1'b1;
                        data_d  = midscale;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (div_tc && dclk_q) begin
                    // Sample slot: new data launches with the falling edge
                    // and is stable for a full half-period before the DAC
                    // latches it on the next rising edge.
                    div_d = cfg_clk_div;
                    if (level_q != '0) begin
                        pop    = 1'b1;
                        data_d = mem[rd_ptr_q];
                    end else begin
                        urun_set = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. Push and pop never touch the same entry: that would
    // need the FIFO to be both full (push blocked) or empty (pop blocked).
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Ready is registered from the next level so it drops on the same
        // cycle the level reaches full.
        ready_d    = (level_d != LVL_FULL);
        running_d  = (state_d == ST_RUN);
        // Set wins over a simultaneous clear.
        underrun_d = urun_set || (underrun_q && !underrun_clr);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q    <= ST_IDLE;
            wake_cnt_q <= '0;
            div_cnt_q  <= '0;
            div_q      <= '0;
            dclk_q     <= 1'b0;
            data_q     <= MID_OB;
            pwrdn_q    <= 1'b1;
            format_q   <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            running_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            dclk_q     <= dclk_d;
            data_q     <= data_d;
            pwrdn_q    <= pwrdn_d;
            format_q   <= cfg_format;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            running_q  <= running_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Sample storage: no reset so it maps onto distributed RAM.
    always_ff @(posedge Bus2IP_Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready    = ready_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign running    = running_q;
    assign S_Data     = data_q;     // data_q MSB lands on S_Data[0]
    assign S_DCLKIO   = dclk_q;
    assign S_PWRDN    = pwrdn_q;
    assign S_Format   = format_q;
    assign S_PinMD    = 1'b1;
    assign S_ClkMD    = 1'b0;

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Scoreboard bench for dac_sample_streamer: the stimulus pushes the expected
// slot values into a queue; a monitor pops and compares at each sample slot.
module tb_dac_sample_streamer;

    localparam int DW    = 10;
    localparam int DEPTH = 16;
    localparam int DIVW  = 16;
    localparam int WAKE  = 64;
    localparam int LVLW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            cfg_enable = 1'b0;
    logic [DIVW-1:0] cfg_clk_div = '0;
    logic            cfg_format = 1'b0;
    logic            underrun_clr = 1'b0;
    logic [LVLW-1:0] fifo_level;
    logic            underrun;
    logic            running;
    logic [0:DW-1]   S_Data;
    logic            S_DCLKIO;
    logic            S_PWRDN;
    logic            S_Format;
    logic            S_PinMD;
    logic            S_ClkMD;

    dac_sample_streamer #(
        .C_DATA_WIDTH (DW),
        .C_FIFO_DEPTH (DEPTH),
        .C_DIV_WIDTH  (DIVW),
        .C_WAKE_CYCLES(WAKE)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Resetn(rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .cfg_enable   (cfg_enable),
        .cfg_clk_div  (cfg_clk_div),
        .cfg_format   (cfg_format),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .running      (running),
        .S_Data       (S_Data),
        .S_DCLKIO     (S_DCLKIO),
        .S_PWRDN      (S_PWRDN),
        .S_Format     (S_Format),
        .S_PinMD      (S_PinMD),
        .S_ClkMD      (S_ClkMD)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int data;
        int urun;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_slots  = 0;
    bit   full_phase = 1'b0;
    bit   prev_dclk  = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input int v);
        int guard;
        bit hs;
        guard   = 0;
        s_data  = v[DW-1:0];
        s_valid = 1'b1;
        do begin
            hs = s_ready;
            tick();
            guard++;
        end while (!hs && guard < 300);
        if (hs) begin
            exp_q.push_back('{data: v, urun: 0});
            $display("push 0x%03h (level now %0d)", v, fifo_level);
        end else begin
            fail_now("push_timeout");
        end
    endtask

    task automatic wait_rise(input int bound, output bit ok);
        bit p;
        p  = S_DCLKIO;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (S_DCLKIO && !p) begin
                ok = 1'b1;
                break;
            end
            p = S_DCLKIO;
        end
    endtask

    // Monitor: a sample slot is a DCLKIO fall while the DAC is powered.
    always @(negedge clk) begin
        if (rst_n && prev_dclk && !S_DCLKIO && !S_PWRDN) begin
            n_slots++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_slot");
            end else begin
                mon_e = exp_q.pop_front();
                $display("slot %0d: S_Data=0x%03h underrun=%0d level=%0d",
                         n_slots, S_Data, underrun, fifo_level);
                check("slot_data", int'(S_Data), mon_e.data);
                check("slot_underrun", int'(underrun), mon_e.urun);
                if (full_phase) begin
                    n_checks++;
                    if (fifo_level < LVLW'(DEPTH - 1)) begin
                        n_fail++;
                        $display("FAIL wrap_level: got %0d, expected >= %0d",
                                 fifo_level, DEPTH - 1);
                    end
                end
            end
        end
        prev_dclk = S_DCLKIO;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lvl;
        int hi;
        bit ok;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_ready", int'(s_ready), 0);
        check("rst_pwrdn", int'(S_PWRDN), 1);
        check("rst_dclk", int'(S_DCLKIO), 0);
        check("rst_data", int'(S_Data), 'h200);
        check("rst_level", int'(fifo_level), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_running", int'(running), 0);
        check("rst_format", int'(S_Format), 0);
        check("pinmd", int'(S_PinMD), 1);
        check("clkmd", int'(S_ClkMD), 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", int'(s_ready), 1);
        check("idle_level", int'(fifo_level), 0);
        check("idle_data", int'(S_Data), 'h200);

        cfg_format = 1'b1;
        tick();
        check("format_reg", int'(S_Format), 1);
        check("midscale_twos", int'(S_Data), 'h000);
        cfg_format = 1'b0;
        tick();
        check("midscale_ob", int'(S_Data), 'h200);

        // ---------------- 4 samples then underrun ----------------
        for (int i = 1; i <= 4; i++) push_sample(i);
        s_valid = 1'b0;
        check("level_4", int'(fifo_level), 4);
        exp_q.push_back('{data: 'h004, urun: 1});
        cfg_clk_div = 16'd2;
        cfg_enable  = 1'b1;
        tick();
        check("pwrdn_fall", int'(S_PWRDN), 0);
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (S_DCLKIO) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_now("first_rise_timeout");
        check("wake_cycles", cyc - t0, WAKE);
        check("first_rise_midscale", int'(S_Data), 'h200);
        check("running_run", int'(running), 1);
        t0 = cyc;
        for (int i = 0; i < 20 && S_DCLKIO; i++) tick();
        check("dclk_high_len", cyc - t0, 3);
        t0 = cyc;
        for (int i = 0; i < 20 && !S_DCLKIO; i++) tick();
        check("dclk_low_len", cyc - t0, 3);

        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_now("underrun_slots_timeout");
        cfg_enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (S_PWRDN) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("stop_timeout");
        check("idle_dclk_low", int'(S_DCLKIO), 0);
        check("idle_midscale", int'(S_Data), 'h200);
        check("underrun_sticky", int'(underrun), 1);
        check("running_idle", int'(running), 0);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("underrun_cleared", int'(underrun), 0);

        // ---------------- fill to full while idle ----------------
        for (int i = 1; i <= 16; i++) push_sample(i);
        check("full_level", int'(fifo_level), 16);
        check("full_ready", int'(s_ready), 0);
        s_data  = 10'h0FF;
        s_valid = 1'b1;
        repeat (4) tick();
        check("overflow_ignored", int'(fifo_level), 16);
        s_valid = 1'b0;

        // ---------------- streaming across pointer wrap ----------------
        cfg_clk_div = 16'd0;
        cfg_enable  = 1'b1;
        full_phase  = 1'b1;
        for (int i = 17; i <= 40; i++) push_sample(i);
        s_valid     = 1'b0;
        full_phase  = 1'b0;
        cfg_clk_div = 16'd3;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() <= 8) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_now("drain_to_8_timeout");

        // ---------------- disable mid-high phase ----------------
        wait_rise(40, ok);
        if (!ok) fail_now("rise_before_stop_timeout");
        cfg_enable = 1'b0;
        lvl = int'(fifo_level);
        hi  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!S_DCLKIO) break;
            hi++;
        end
        check("stop_high_len", hi, 3);
        check("stop_pwrdn", int'(S_PWRDN), 1);
        check("stop_midscale", int'(S_Data), 'h200);
        check("stop_running", int'(running), 0);
        check("stop_no_pop", int'(fifo_level), lvl);
        check("retained_level", int'(fifo_level), exp_q.size());

        // ---------------- drain retained data, reset during RUN ----------------
        cfg_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_now("retained_drain_timeout");
        wait_rise(20, ok);
        if (!ok) fail_now("rise_before_reset_timeout");
        rst_n = 1'b0;
        #1;
        check("arst_dclk", int'(S_DCLKIO), 0);
        check("arst_pwrdn", int'(S_PWRDN), 1);
        check("arst_level", int'(fifo_level), 0);
        check("arst_underrun", int'(underrun), 0);
        check("arst_ready", int'(s_ready), 0);
        check("arst_running", int'(running), 0);
        cfg_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rerelease_ready", int'(s_ready), 1);
        check("rerelease_data", int'(S_Data), 'h200);
        check("rerelease_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
